sdram_ch_responder: RTL
=======================

// Module: sdram_ch_responder
// PURPOSE
//  Target-side model of the 8-bit SDRAM channel interface (ch_addr/ch_wr/ch_din/ch_rd/ch_dout/ch_busy/refresh).
//  It answers channel requests from a byte RAM with programmable busy latency and refresh stalls.
//  It drops into the top level in place of the sdram controller for sim and BRAM-only bring-up of the framebuffer and memory-test logic.
// PARAMETERS
//  ADDR_W       25  channel address width
//  DEPTH_LOG2   10  backing store = 2**DEPTH_LOG2 bytes; ch_addr[DEPTH_LOG2-1:0] used, upper bits ignored (wrap)
//  LATENCY      4   busy cycles per access, legal 1..15
//  REFRESH_CYC  6   busy cycles per refresh, legal 1..15
// PORTS
//  clk_sys     in   1       single clock, all logic posedge
//  reset       in   1       synchronous, active-high
//  ch_addr     in   ADDR_W  byte address, sampled at accept
//  ch_wr       in   1       write request, level; accepted on rising edge
//  ch_din      in   8       write data, sampled at accept
//  ch_rd       in   1       read request, level; accepted on rising edge
//  ch_dout     out  8       read data, valid from busy fall until next read completes
//  ch_busy     out  1       high while an access or refresh is in progress
//  refresh     in   1       refresh request, 1-cycle pulse or level (rising edge)
//  stat_rd     out  16      completed reads      (SDRAM_RESP_STATS_EN)
//  stat_wr     out  16      completed writes     (SDRAM_RESP_STATS_EN)
//  stat_err    out  1       sticky protocol error (SDRAM_RESP_STATS_EN)
// BEHAVIOUR
//  Reset: ch_busy=0, ch_dout=0, state=IDLE, pending flags=0, edge regs prev_rd/prev_wr/prev_ref=0. RAM not cleared.
//  Reset exit: a request held high through reset is seen as an edge on the first cycle out of reset.
//  Edges: rise_x = x & ~prev_x, registered each cycle. Edges arriving outside IDLE set pend_wr/pend_rd/pend_ref.
//  FSM:
//   IDLE: priority pend/rise wr > rd > refresh. Accept latches addr/din/op, cnt<=LATENCY-1, ch_busy<=1, goes to ACCESS.
//         Refresh accept: cnt<=REFRESH_CYC-1, ch_busy<=1, goes to REFR.
//   ACCESS: cnt decrements. At cnt==0: write commits RAM[addr]<=din, or read loads ch_dout<=RAM[addr];
//         ch_busy<=0, back to IDLE.
//   REFR: cnt decrements; at cnt==0 ch_busy<=0, back to IDLE.
//  Latency: accept edge at cycle N -> ch_busy=1 at N+1 .. N+LATENCY; busy=0 and ch_dout valid at N+LATENCY+1.
//  The IDLE cycle after busy falls is a gap cycle. Back-to-back accept earliest one cycle after busy falls.
//  Simultaneous rd+wr rise: write serviced first, read pended, then read observes new data.
//  Refresh coincident with request: request wins, refresh pended. Multiple refresh edges while pended collapse to one.
//  Same-op edge while that op is already pending: dropped, stat_err set.
//  Read-after-write to the same addr returns the written byte. ch_dout is unchanged by writes and refreshes.
//  Reset mid-access: aborted, write not committed, ch_dout cleared, pendings cleared.
//  cnt is 4 bits; LATENCY/REFRESH_CYC out of range is a compile-time $error.
// CONFIGURATION
//  SDRAM_RESP_STATS_EN defined:
//   stat_rd/stat_wr increment at commit and saturate at 16'hFFFF.
//   stat_err sets on a dropped edge or a request edge during REFR for the same op already pending; clears only on reset.
//  Undefined: stat_* tied 0, counters not synthesised; core behaviour identical.
// STRUCTURE
//  Package sdram_resp_pkg:
//   state enum {IDLE, ACCESS, REFR}
//   op enum {OP_RD, OP_WR}
//   CNT_W=4, default LATENCY/REFRESH_CYC constants
//  Sub-module sdram_resp_mem: single-port 8-bit RAM, 2**DEPTH_LOG2 deep, sync write, registered read, BRAM-inferable.
//   ACCESS issues the RAM read one cycle before cnt==0 to cover its read latency.
// TESTING
//  1 Reset, wr addr 0x005 din 0xA5, LATENCY=4 -> busy high exactly 4 cycles; then rd 0x005 -> ch_dout=0xA5 when busy falls.
//  2 Write bytes = addr[7:0] over 0..255, read back with the top-level test FSM -> zero mismatches, stat_rd=256, stat_wr=256.
//  3 rd+wr rise same cycle, addr 0x010, din 0x3C -> write first, then read returns 0x3C; total busy 2*LATENCY+gap.
//  4 refresh pulse with rd edge, addr 0x000 -> read serviced first, then busy REFRESH_CYC=6 cycles; ch_dout stable through refresh.
//  5 wr 0x3FF then 0x400 (DEPTH_LOG2=10) with din 0x11/0x22 -> rd 0x3FF=0x11, rd 0x000=0x22 (wrap).
//  6 reset asserted at cycle 2 of a write to 0x020 din 0x77 -> busy=0 next cycle; rd 0x020 returns prior contents, not 0x77.

Source files
------------

// File: rtl/sdram_resp_pkg.sv
// Shared types and constants for the SDRAM channel responder.
package sdram_resp_pkg;

  localparam int CNT_W           = 4;
  localparam int LATENCY_DEF     = 4;
  localparam int REFRESH_CYC_DEF = 6;

  typedef enum logic [1:0] {IDLE, ACCESS, REFR} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;

endpackage

// File: rtl/sdram_ch_responder_if.sv
// 8-bit SDRAM channel bus; master is the requester, slave the responder.
interface sdram_ch_responder_if #(
  parameter int ADDR_W = 25
) ();

  logic [ADDR_W-1:0] ch_addr;
  logic              ch_wr;
  logic [7:0]        ch_din;
  logic              ch_rd;
  logic [7:0]        ch_dout;
  logic              ch_busy;
  logic              refresh;

  modport master (
    output ch_addr, ch_wr, ch_din, ch_rd, refresh,
    input  ch_dout, ch_busy
  );

  modport slave (
    input  ch_addr, ch_wr, ch_din, ch_rd, refresh,
    output ch_dout, ch_busy
  );

endinterface

// File: rtl/sdram_resp_mem.sv
// Single-port byte RAM with synchronous write and registered read (BRAM style).
module sdram_resp_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_sys,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk_sys) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_ch_responder.sv
// Target-side SDRAM channel model: byte RAM behind busy latency and refresh stalls.
// Optional statistics (stat_rd/stat_wr/stat_err) built when SDRAM_RESP_STATS_EN is defined.
module sdram_ch_responder
  import sdram_resp_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter int DEPTH_LOG2  = 10,
  parameter int LATENCY     = LATENCY_DEF,
  parameter int REFRESH_CYC = REFRESH_CYC_DEF
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  sdram_ch_responder_if.slave  ch,
  output logic [15:0]          stat_rd,
  output logic [15:0]          stat_wr,
  output logic                 stat_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("LATENCY must be in 1..15");
  end
  if (REFRESH_CYC < 1 || REFRESH_CYC > 15) begin : g_ref_chk
    $error("REFRESH_CYC must be in 1..15");
  end

  state_e                 state_p0, state_n;
  logic [CNT_W-1:0]       cnt_p0, cnt_n;
  logic                   prev_wr, prev_rd, prev_ref;
  logic                   pend_wr, pend_rd, pend_ref;
  logic                   rise_wr, rise_rd, rise_ref;
  logic                   take_wr, take_rd, take_ref;
  logic [DEPTH_LOG2-1:0]  addr_p0;
  logic [7:0]             din_p0;
  op_e                    op_p0;
  logic [7:0]             dout_p0;
  logic                   busy, commit, mem_we, mem_re, dout_ld;
  logic [DEPTH_LOG2-1:0]  mem_addr;
  logic [7:0]             mem_rdata;
  logic                   unused_addr;

  // Upper address bits are ignored: the store wraps.
  assign unused_addr = ^ch.ch_addr[ADDR_W-1:DEPTH_LOG2];

  assign rise_wr  = ch.ch_wr   & ~prev_wr;
  assign rise_rd  = ch.ch_rd   & ~prev_rd;
  assign rise_ref = ch.refresh & ~prev_ref;

  // ---- state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_n;
      cnt_p0   <= cnt_n;
    end
  end

  // ---- next state: priority write > read > refresh
  always_comb begin
    state_n  = state_p0;
    cnt_n    = cnt_p0;
    take_wr  = 1'b0;
    take_rd  = 1'b0;
    take_ref = 1'b0;
    case (state_p0)
      IDLE: begin
        if (pend_wr | rise_wr) begin
          take_wr = 1'b1;
          state_n = ACCESS;
          cnt_n   = CNT_W'(LATENCY - 1);
        end else if (pend_rd | rise_rd) begin
          take_rd = 1'b1;
          state_n = ACCESS;
          cnt_n   = CNT_W'(LATENCY - 1);
        end else if (pend_ref | rise_ref) begin
          take_ref = 1'b1;
          state_n  = REFR;
          cnt_n    = CNT_W'(REFRESH_CYC - 1);
        end
      end
      ACCESS, REFR: begin
        if (cnt_p0 == '0) state_n = IDLE;
        else              cnt_n   = cnt_p0 - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- outputs; RAM read is issued one cycle ahead of completion
  always_comb begin
    busy     = (state_p0 != IDLE);
    commit   = (state_p0 == ACCESS) && (cnt_p0 == '0) && !reset;
    mem_we   = commit && (op_p0 == OP_WR);
    dout_ld  = commit && (op_p0 == OP_RD);
    mem_re   = ((state_p0 == ACCESS) && (op_p0 == OP_RD) && (cnt_p0 == CNT_W'(1)))
             || ((LATENCY == 1) && take_rd);
    mem_addr = (state_p0 == IDLE) ? ch.ch_addr[DEPTH_LOG2-1:0] : addr_p0;
  end

  // An edge taken from pending leaves a coincident new edge pending.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_wr  <= 1'b0;
      prev_rd  <= 1'b0;
      prev_ref <= 1'b0;
      pend_wr  <= 1'b0;
      pend_rd  <= 1'b0;
      pend_ref <= 1'b0;
    end else begin
      prev_wr  <= ch.ch_wr;
      prev_rd  <= ch.ch_rd;
      prev_ref <= ch.refresh;
      pend_wr  <= take_wr  ? (pend_wr  & rise_wr)  : (pend_wr  | rise_wr);
      pend_rd  <= take_rd  ? (pend_rd  & rise_rd)  : (pend_rd  | rise_rd);
      pend_ref <= take_ref ? (pend_ref & rise_ref) : (pend_ref | rise_ref);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (take_wr | take_rd) begin
      addr_p0 <= ch.ch_addr[DEPTH_LOG2-1:0];
      din_p0  <= ch.ch_din;
      op_p0   <= take_wr ? OP_WR : OP_RD;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)        dout_p0 <= '0;
    else if (dout_ld) dout_p0 <= mem_rdata;
  end

  assign ch.ch_dout = dout_p0;
  assign ch.ch_busy = busy;

  sdram_resp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk_sys (clk_sys),
    .we      (mem_we),
    .re      (mem_re),
    .addr    (mem_addr),
    .wdata   (din_p0),
    .rdata   (mem_rdata)
  );

`ifdef SDRAM_RESP_STATS_EN
  logic drop_err;
  assign drop_err = (rise_wr & pend_wr & ~take_wr) | (rise_rd & pend_rd & ~take_rd);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= 1'b0;
    end else begin
      if (dout_ld && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      if (mem_we  && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
      if (drop_err) stat_err <= 1'b1;
    end
  end
`else
  assign stat_rd  = '0;
  assign stat_wr  = '0;
  assign stat_err = 1'b0;
`endif

endmodule
